sram_mem_ctrl: RTL and testbench
================================

// Module: sram_mem_ctrl
// PURPOSE
//  MEM-stage responder for the pipeline's data-memory requests: turns a 32-bit word read/write into two
//  16-bit accesses on the external SRAM and returns the word that memReg latches as data_mem.
//  ready is held low during an access so the hazard/freeze logic stalls IF..EXE and the EXE/MEM register.
// PARAMETERS
//  BASE_ADDR    1024  byte address mapped to SRAM word 0; pipeline address minus BASE_ADDR, modulo 2^32
//  SRAM_AW      18    SRAM half-word address width
//  WAIT_CYCLES  1     extra cycles per half-word phase; minimum 1; phase length P = WAIT_CYCLES+1
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst        in   1        asynchronous, active-low reset
//  MEM_R_EN   in   1        read request, held stable by pipeline until ready=1
//  MEM_W_EN   in   1        write request, held stable until ready=1
//  address    in   32       byte address (alu_res), word-aligned; bits [1:0] ignored
//  wr_data    in   32       store data (Val_Rm)
//  rd_data    out  32       last completed read word (feeds memReg data_mem)
//  ready      out  1        1 = no access pending/access completes this cycle; 0 = freeze pipeline
//  SRAM_DQ    inout 16      SRAM data bus
//  SRAM_ADDR  out  SRAM_AW  half-word address
//  SRAM_WE_N, SRAM_OE_N  out 1  active-low write / output enables
//  SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out 1  tied 0
// BEHAVIOUR
//  - Reset (rst=0): state IDLE, cnt=0, rd_data=0, lo_buf=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, DQ=Z.
//  - word = (address-BASE_ADDR)>>2; LO phase SRAM_ADDR={word,1'b0} (bits [15:0]), HI phase {word,1'b1}.
//  - FSM: IDLE -> LO on (MEM_R_EN|MEM_W_EN); LO -> HI after P cycles; HI -> DONE after P cycles;
//    DONE -> IDLE unconditionally. cnt counts 0..P-1 within a phase, cleared on phase change.
//  - ready (combinational) = (IDLE & ~MEM_R_EN & ~MEM_W_EN) | DONE. Request first seen in IDLE: ready=0 that
//    cycle. ready low for exactly 1+2P cycles, high for the DONE cycle; pipeline advances on that edge.
//  - Request present in DONE cycle is NOT restarted there; next request evaluated in following IDLE cycle.
//  - Both enables high: write has priority, operation latched on IDLE->LO (is_write reg); request changes
//    after IDLE are ignored until DONE.
//  - Read: SRAM_OE_N=0 in LO/HI; DQ sampled on last cycle of LO into lo_buf, on last cycle of HI
//    rd_data <= {DQ, lo_buf}. rd_data changes only then; holds value otherwise (incl. across writes).
//  - Write: DQ driven wr_data[15:0] in LO, wr_data[31:16] in HI, Z otherwise; SRAM_WE_N=0 on cycles
//    0..P-2 of each phase, 1 on last cycle (address/data stable across WE_N rising edge). OE_N=1.
//  - SRAM outputs registered from next-state decode, so ADDR/WE_N/DQ are glitch-free.
//  - Reset mid-access: immediate return to IDLE, bus released; a write may leave only its low half written.
//  - Address below BASE_ADDR wraps modulo; no range check.
// STRUCTURE
//  - arm_pkg: typedef enum logic[1:0] {S_IDLE,S_LO,S_HI,S_DONE} sram_state_t; SRAM_BASE_ADDR const.
//  - No sub-module: FSM, phase counter, lo_buf, tri-state driver in one module (~150 lines).
// TESTING
//  - Reset: rst=0 mid-run -> rd_data=0, ready=1 with no request, WE_N=1, OE_N=1, DQ=Z.
//  - Write 0xDEADBEEF @1028, P=2 -> ADDR=2 DQ=0xBEEF then ADDR=3 DQ=0xDEAD; ready low 5 cycles, then 1.
//  - Read back @1028 -> rd_data=0xDEADBEEF at DONE; rd_data unchanged before HI completes.
//  - Back-to-back: request held through DONE -> one IDLE cycle (ready=0) then second access starts.
//  - R and W both high @1024 -> write performed, rd_data unchanged.
//  - rst pulse during HI of a write -> IDLE next edge, WE_N=1, only low half updated in SRAM model.

Source files
------------

// File: rtl/sram_mem_ctrl_pkg.sv
// Shared constants and helpers for the MEM-stage SRAM controller.
//  - SRAM_BASE_ADDR : pipeline byte address that maps onto SRAM half-word pair 0
//  - S_*            : FSM state encodings (2-bit, kept as plain constants for
//                     compatibility with older tooling and waveform decoders)
//  - half_addr()    : byte address -> SRAM half-word address (low or high half)
package sram_mem_ctrl_pkg;

  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Word index is (byte - base) >> 2, wrapping modulo 2^32 so addresses below
  // the base alias to the top of the SRAM. Each word occupies two half-words,
  // the low half at the even address.
  function automatic logic [31:0] half_addr(input logic [31:0] byte_addr,
                                            input logic [31:0] base,
                                            input logic        hi);
    return (((byte_addr - base) >> 5'd2) << 5'd1) | {31'd0, hi};
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Pipeline <-> data-memory handshake.
//  mem_r_en / mem_w_en : read / write request, held by the pipeline until ready=1
//  address             : word-aligned byte address (alu result)
//  wr_data             : store data
//  rd_data             : last completed read word
//  ready               : 0 = access in progress, freeze the pipeline
// master = pipeline side, slave = memory controller side.
interface sram_mem_ctrl_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, address, wr_data,
    input  rd_data, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, wr_data,
    output rd_data, ready
  );

endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory responder. A 32-bit word access becomes two 16-bit
// accesses on an asynchronous external SRAM (low half first, then high half),
// each lasting P = WAIT_CYCLES+1 clock cycles.
// Ports:
//  clk                 clock, all state on the rising edge
//  rst                 asynchronous active-low reset
//  bus (slave)         pipeline handshake (requests, address, data, ready)
//  sram_dq             bidirectional SRAM data bus
//  sram_addr           SRAM half-word address
//  sram_we_n/sram_oe_n active-low write / output enables
//  sram_ce_n/ub_n/lb_n permanently enabled (tied low)
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_ctrl_if.slave     bus,
  inout  wire  [15:0]        sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int P = WAIT_CYCLES + 1;
  localparam int CNT_W = $clog2(P);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [1:0]         state_r, next_state_s;
  logic [CNT_W-1:0]   cnt_r, next_cnt_s;
  logic               is_write_r, next_is_write_s;
  logic               req_s, phase_last_s;
  logic [SRAM_AW-1:0] lo_addr_s, hi_addr_s;

  logic [15:0]        lo_buf_r;
  logic [31:0]        rd_data_r;

  logic [SRAM_AW-1:0] sram_addr_r, next_addr_s;
  logic               we_n_r, next_we_n_s;
  logic               oe_n_r, next_oe_n_s;
  logic               dq_oe_r, next_dq_oe_s;
  logic [15:0]        dq_out_r, next_dq_s;
  logic               next_access_s, next_last_s;

  assign req_s        = bus.mem_r_en | bus.mem_w_en;
  assign phase_last_s = (cnt_r == CNT_LAST);
  assign lo_addr_s    = SRAM_AW'(half_addr(bus.address, BASE_ADDR, 1'b0));
  assign hi_addr_s    = SRAM_AW'(half_addr(bus.address, BASE_ADDR, 1'b1));

  // The request is only looked at in IDLE, so a request still asserted during
  // DONE costs one IDLE cycle before the next access begins.
  assign bus.ready   = ((state_r == S_IDLE) && !req_s) || (state_r == S_DONE);
  assign bus.rd_data = rd_data_r;

  // Next-state / phase-counter decode.
  always_comb begin
    next_state_s    = state_r;
    next_cnt_s      = cnt_r;
    next_is_write_s = is_write_r;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          next_state_s    = S_LO;
          next_cnt_s      = CNT_ZERO;
          next_is_write_s = bus.mem_w_en;   // write wins when both are high
        end else begin
          next_state_s    = S_IDLE;
          next_cnt_s      = CNT_ZERO;
        end
      end
      S_LO: begin
        if (phase_last_s) begin
          next_state_s = S_HI;
          next_cnt_s   = CNT_ZERO;
        end else begin
          next_cnt_s   = cnt_r + CNT_ONE;
        end
      end
      S_HI: begin
        if (phase_last_s) begin
          next_state_s = S_DONE;
          next_cnt_s   = CNT_ZERO;
        end else begin
          next_cnt_s   = cnt_r + CNT_ONE;
        end
      end
      S_DONE: begin
        next_state_s = S_IDLE;
        next_cnt_s   = CNT_ZERO;
      end
      default: begin
        next_state_s = S_IDLE;
        next_cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // SRAM pin values for the coming cycle, decoded from the next state so the
  // registered pins change cleanly on the clock edge. WE_N rises for the last
  // cycle of each write phase while address and data are still held.
  always_comb begin
    next_access_s = (next_state_s == S_LO) || (next_state_s == S_HI);
    next_last_s   = (next_cnt_s == CNT_LAST);
    next_addr_s   = sram_addr_r;
    next_we_n_s   = 1'b1;
    next_oe_n_s   = 1'b1;
    next_dq_oe_s  = 1'b0;
    next_dq_s     = dq_out_r;
    if (next_state_s == S_LO) begin
      next_addr_s = lo_addr_s;
      next_dq_s   = bus.wr_data[15:0];
    end else if (next_state_s == S_HI) begin
      next_addr_s = hi_addr_s;
      next_dq_s   = bus.wr_data[31:16];
    end else begin
      next_addr_s = sram_addr_r;
    end
    if (next_access_s && next_is_write_s) begin
      next_we_n_s  = next_last_s;
      next_dq_oe_s = 1'b1;
    end else if (next_access_s) begin
      next_oe_n_s  = 1'b0;
    end else begin
      next_we_n_s  = 1'b1;
      next_oe_n_s  = 1'b1;
    end
  end

  // FSM state, phase counter and latched operation type.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= CNT_ZERO;
      is_write_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      cnt_r      <= next_cnt_s;
      is_write_r <= next_is_write_s;
    end
  end

  // Registered SRAM pins; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr_r <= {SRAM_AW{1'b0}};
      we_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      dq_oe_r     <= 1'b0;
      dq_out_r    <= 16'h0000;
    end else begin
      sram_addr_r <= next_addr_s;
      we_n_r      <= next_we_n_s;
      oe_n_r      <= next_oe_n_s;
      dq_oe_r     <= next_dq_oe_s;
      dq_out_r    <= next_dq_s;
    end
  end

  // Read capture: low half at the end of LO, whole word at the end of HI.
  // rd_data changes nowhere else, so it survives writes untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_buf_r  <= 16'h0000;
      rd_data_r <= 32'h0000_0000;
    end else if (!is_write_r && phase_last_s && (state_r == S_LO)) begin
      lo_buf_r  <= sram_dq;
    end else if (!is_write_r && phase_last_s && (state_r == S_HI)) begin
      rd_data_r <= {sram_dq, lo_buf_r};
    end else begin
      lo_buf_r  <= lo_buf_r;
      rd_data_r <= rd_data_r;
    end
  end

  assign sram_dq   = dq_oe_r ? dq_out_r : {16{1'bz}};
  assign sram_addr = sram_addr_r;
  assign sram_we_n = we_n_r;
  assign sram_oe_n = oe_n_r;
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl (BASE_ADDR=1024, WAIT_CYCLES=1, P=2).
// A behavioural asynchronous SRAM commits writes on the WE_N rising edge and
// checks each committed half-word against a queue of expected writes; read
// results are checked against a queue of expected words.
module tb_sram_mem_ctrl;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
  } wr_ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  logic [15:0] mem [0:262143];
  wr_ev_t      wq[$];
  logic [31:0] rq[$];
  int          checks = 0;
  int          passed = 0;

  sram_mem_ctrl_if bus ();

  sram_mem_ctrl #(
    .BASE_ADDR  (32'd1024),
    .SRAM_AW    (18),
    .WAIT_CYCLES(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sram_dq  (sram_dq),
    .sram_addr(sram_addr),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n),
    .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // SRAM model: drives data while output-enabled and not writing.
  assign sram_dq = (rst && !sram_oe_n && sram_we_n) ? mem[sram_addr] : {16{1'bz}};

  // SRAM model write port; a WE_N rise caused by reset is an aborted write.
  initial begin
    forever begin
      @(posedge sram_we_n);
      if (rst === 1'b1) begin
        wr_ev_t e;
        checks++;
        if (wq.size() == 0) begin
          $display("FAIL sram_write_unexpected: got addr=%h data=%h, required none", sram_addr, sram_dq);
        end else begin
          e = wq.pop_front();
          if (sram_addr !== e.a || sram_dq !== e.d)
            $display("FAIL sram_write: got addr=%h data=%h, required addr=%h data=%h",
                     sram_addr, sram_dq, e.a, e.d);
          else
            passed++;
        end
        mem[sram_addr] = sram_dq;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One word access: drive at a negedge and sample 1ns later until ready.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int low, output int oe_low, output int we_low,
                        output bit rd_moved, output bit done);
    logic [31:0] rd0;
    @(negedge clk);
    bus.mem_r_en = r; bus.mem_w_en = w; bus.address = a; bus.wr_data = d;
    #1;
    rd0 = bus.rd_data; low = 0; oe_low = 0; we_low = 0; rd_moved = 1'b0; done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready) begin
        done = 1'b1;
        break;
      end
      low++;
      if (!sram_oe_n) oe_low++;
      if (!sram_we_n) we_low++;
      if (bus.rd_data !== rd0) rd_moved = 1'b1;
      @(negedge clk);
      #1;
    end
    if (!done) $display("FAIL access_timeout: ready never rose for addr %h", a);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0; bus.address = 32'd0; bus.wr_data = 32'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", bus.ready); else passed++;
    checks++; if (bus.rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h, required 0", bus.rd_data); else passed++;
    checks++; if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1)
      $display("FAIL reset_enables: got we_n=%b oe_n=%b, required 1 1", sram_we_n, sram_oe_n); else passed++;
    checks++; if (sram_addr !== 18'd0) $display("FAIL reset_addr: got %h, required 0", sram_addr); else passed++;
    checks++; if ({sram_ce_n, sram_ub_n, sram_lb_n} !== 3'b000)
      $display("FAIL tie_offs: got %b, required 000", {sram_ce_n, sram_ub_n, sram_lb_n}); else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write();
    int low, oel, wel; bit mv, ok;
    wq.push_back('{18'd2, 16'hBEEF});
    wq.push_back('{18'd3, 16'hDEAD});
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, low, oel, wel, mv, ok);
    checks++; if (!ok || low != 5) $display("FAIL write_ready_low: got %0d cycles, required 5", low); else passed++;
    checks++; if (wel != 2 || oel != 0)
      $display("FAIL write_strobes: got we_low=%0d oe_low=%0d, required 2 0", wel, oel); else passed++;
    checks++; if (bus.rd_data !== 32'h0) $display("FAIL write_rd_hold: got %h, required 0", bus.rd_data); else passed++;
    idle_bus();
  endtask

  task automatic test_read();
    int low, oel, wel; bit mv, ok;
    rq.push_back(32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1028, 32'h0, low, oel, wel, mv, ok);
    checks++; if (!ok || low != 5) $display("FAIL read_ready_low: got %0d cycles, required 5", low); else passed++;
    checks++; if (oel != 4 || wel != 0)
      $display("FAIL read_strobes: got oe_low=%0d we_low=%0d, required 4 0", oel, wel); else passed++;
    checks++; if (mv) $display("FAIL read_early_update: got rd_data change before DONE, required none"); else passed++;
    checks++; if (bus.rd_data !== rq[0]) $display("FAIL read_data: got %h, required %h", bus.rd_data, rq[0]); else passed++;
    void'(rq.pop_front());
    idle_bus();
    @(negedge clk); #1;
    checks++; if (bus.rd_data !== 32'hDEADBEEF) $display("FAIL read_hold: got %h, required deadbeef", bus.rd_data); else passed++;
  endtask

  task automatic test_back_to_back();
    int low, oel, wel; bit mv, ok;
    wq.push_back('{18'd4, 16'hF00D});
    wq.push_back('{18'd5, 16'h0BAD});
    wq.push_back('{18'd4, 16'hF00D});
    wq.push_back('{18'd5, 16'h0BAD});
    access(1'b0, 1'b1, 32'd1032, 32'h0BADF00D, low, oel, wel, mv, ok);
    // Request held through DONE: the following IDLE cycle must show ready=0.
    @(negedge clk); #1;
    checks++; if (bus.ready !== 1'b0) $display("FAIL b2b_idle_ready: got %b, required 0", bus.ready); else passed++;
    @(posedge clk); #1;
    checks++; if (sram_addr !== 18'd4 || sram_we_n !== 1'b0)
      $display("FAIL b2b_restart: got addr=%h we_n=%b, required 4 0", sram_addr, sram_we_n); else passed++;
    for (int i = 0; i < 40 && !bus.ready; i++) @(negedge clk);
    // Read straight after, then another read with no idle gap in between.
    rq.push_back(32'h0BADF00D);
    access(1'b1, 1'b0, 32'd1032, 32'h0, low, oel, wel, mv, ok);
    checks++; if (bus.rd_data !== rq[0]) $display("FAIL b2b_read1: got %h, required %h", bus.rd_data, rq[0]); else passed++;
    void'(rq.pop_front());
    rq.push_back(32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1028, 32'h0, low, oel, wel, mv, ok);
    checks++; if (!ok || low != 5) $display("FAIL b2b_read2_low: got %0d cycles, required 5", low); else passed++;
    checks++; if (bus.rd_data !== rq[0]) $display("FAIL b2b_read2: got %h, required %h", bus.rd_data, rq[0]); else passed++;
    void'(rq.pop_front());
    idle_bus();
  endtask

  task automatic test_both_en();
    int low, oel, wel; bit mv, ok;
    logic [31:0] prev;
    prev = bus.rd_data;
    wq.push_back('{18'd0, 16'h4321});
    wq.push_back('{18'd1, 16'h8765});
    access(1'b1, 1'b1, 32'd1024, 32'h87654321, low, oel, wel, mv, ok);
    checks++; if (bus.rd_data !== prev) $display("FAIL both_rd_hold: got %h, required %h", bus.rd_data, prev); else passed++;
    checks++; if (wel != 2) $display("FAIL both_is_write: got we_low=%0d, required 2", wel); else passed++;
    idle_bus();
    rq.push_back(32'h87654321);
    access(1'b1, 1'b0, 32'd1024, 32'h0, low, oel, wel, mv, ok);
    checks++; if (bus.rd_data !== rq[0]) $display("FAIL both_readback: got %h, required %h", bus.rd_data, rq[0]); else passed++;
    void'(rq.pop_front());
    idle_bus();
  endtask

  task automatic test_wrap();
    int low, oel, wel; bit mv, ok;
    // 1020 - 1024 wraps to word 0x3FFFFFFF -> half-words 0x3FFFE/0x3FFFF.
    wq.push_back('{18'h3FFFE, 16'hF00D});
    wq.push_back('{18'h3FFFF, 16'hCAFE});
    access(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, low, oel, wel, mv, ok);
    idle_bus();
    rq.push_back(32'hCAFEF00D);
    access(1'b1, 1'b0, 32'd1020, 32'h0, low, oel, wel, mv, ok);
    checks++; if (bus.rd_data !== rq[0]) $display("FAIL wrap_readback: got %h, required %h", bus.rd_data, rq[0]); else passed++;
    void'(rq.pop_front());
    idle_bus();
  endtask

  task automatic test_reset_mid_write();
    int low, oel, wel; bit mv, ok;
    wq.push_back('{18'd8, 16'h5555});
    wq.push_back('{18'd9, 16'hAAAA});
    access(1'b0, 1'b1, 32'd1040, 32'hAAAA5555, low, oel, wel, mv, ok);
    idle_bus();
    wq.push_back('{18'd8, 16'h5678});      // high half never commits
    @(negedge clk);
    bus.mem_w_en = 1'b1; bus.address = 32'd1040; bus.wr_data = 32'h12345678;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sram_addr !== 18'd9 || sram_we_n !== 1'b0)
      $display("FAIL abort_in_hi: got addr=%h we_n=%b, required 9 0", sram_addr, sram_we_n); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_addr !== 18'd0)
      $display("FAIL abort_release: got we_n=%b oe_n=%b addr=%h, required 1 1 0", sram_we_n, sram_oe_n, sram_addr); else passed++;
    checks++; if (bus.rd_data !== 32'h0) $display("FAIL abort_rd_clear: got %h, required 0", bus.rd_data); else passed++;
    bus.mem_w_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b1) $display("FAIL abort_idle_ready: got %b, required 1", bus.ready); else passed++;
    rq.push_back(32'hAAAA5678);
    access(1'b1, 1'b0, 32'd1040, 32'h0, low, oel, wel, mv, ok);
    checks++; if (bus.rd_data !== rq[0]) $display("FAIL abort_readback: got %h, required %h", bus.rd_data, rq[0]); else passed++;
    void'(rq.pop_front());
    idle_bus();
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_both_en();
    test_wrap();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    checks++; if (wq.size() != 0) $display("FAIL pending_writes: got %0d left, required 0", wq.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
